// File: rtl/eth_pkt_if_pkt_gate.sv
// Packet-boundary-aware flow gate: opens/closes a packet stream only between packets.
// Optional statistics counters are enabled by defining ETH_PKT_GATE_STAT_EN.
module eth_pkt_if_pkt_gate #(
    parameter int    DATA_W     = 64,
    parameter int    TUSER_W    = 1,
    parameter int    MOD_W      = (DATA_W > 8) ? $clog2(DATA_W / 8) : 1,
    parameter string GATED_MODE = "HOLD"
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               enable_i,
    input  logic [DATA_W-1:0]  pkt_i_data,
    input  logic [TUSER_W-1:0] pkt_i_tuser,
    input  logic               pkt_i_sop,
    input  logic               pkt_i_eop,
    input  logic [MOD_W-1:0]   pkt_i_mod,
    input  logic               pkt_i_val,
    output logic               pkt_i_ready,
    output logic [DATA_W-1:0]  pkt_o_data,
    output logic [TUSER_W-1:0] pkt_o_tuser,
    output logic               pkt_o_sop,
    output logic               pkt_o_eop,
    output logic [MOD_W-1:0]   pkt_o_mod,
    output logic               pkt_o_val,
    input  logic               pkt_o_ready,
    output logic               gate_open_o,
    output logic               busy_o,
    output logic               orphan_o
`ifdef ETH_PKT_GATE_STAT_EN
   ,input  logic               stat_clr_i,
    output logic [31:0]        pkt_pass_cnt_o,
    output logic [31:0]        pkt_drop_cnt_o
`endif
);

    localparam bit DROP_MODE = (GATED_MODE == "DROP");

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PASS = 2'd1,
        S_DROP = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   en_q, en_d;
    logic   orphan_q, orphan_d;
    logic   beat;
    logic   pass_inc, drop_inc;

    assign pkt_o_data  = pkt_i_data;
    assign pkt_o_tuser = pkt_i_tuser;
    assign pkt_o_sop   = pkt_i_sop;
    assign pkt_o_eop   = pkt_i_eop;
    assign pkt_o_mod   = pkt_i_mod;

    assign beat        = pkt_i_val & pkt_i_ready;
    assign gate_open_o = en_q;
    assign busy_o      = (state_q != S_IDLE);
    assign orphan_o    = orphan_q;
    assign en_d        = enable_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            en_q     <= 1'b0;
            orphan_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            orphan_q <= orphan_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        orphan_d = 1'b0;
        pass_inc = 1'b0;
        drop_inc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (beat) begin
                    if (!pkt_i_sop) begin
                        orphan_d = 1'b1;
                    end else if (pkt_i_eop) begin
                        pass_inc = en_q;
                        drop_inc = !en_q && DROP_MODE;
                    end else if (en_q) begin
                        state_d = S_PASS;
                    end else if (DROP_MODE) begin
                        state_d = S_DROP;
                    end
                end
            end
            S_PASS: begin
                if (beat) begin
                    // A sop here means the previous packet lost its eop.
                    orphan_d = pkt_i_sop;
                    if (pkt_i_eop) begin
                        state_d  = S_IDLE;
                        pass_inc = 1'b1;
                    end
                end
            end
            S_DROP: begin
                if (beat && pkt_i_eop) begin
                    state_d  = S_IDLE;
                    drop_inc = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pkt_o_val   = 1'b0;
        pkt_i_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pkt_i_val && !pkt_i_sop) begin
                    pkt_i_ready = 1'b1;
                end else if (en_q) begin
                    pkt_o_val   = pkt_i_val;
                    pkt_i_ready = pkt_o_ready;
                end else begin
                    pkt_i_ready = DROP_MODE;
                end
            end
            S_PASS: begin
                pkt_o_val   = pkt_i_val;
                pkt_i_ready = pkt_o_ready;
            end
            S_DROP: begin
                pkt_i_ready = 1'b1;
            end
            default: begin
                pkt_o_val   = 1'b0;
                pkt_i_ready = 1'b0;
            end
        endcase
    end

`ifdef ETH_PKT_GATE_STAT_EN
    logic [31:0] pass_cnt_q, pass_cnt_d;
    logic [31:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        pass_cnt_d = pass_cnt_q + {31'd0, pass_inc};
        drop_cnt_d = drop_cnt_q + {31'd0, drop_inc};
        if (stat_clr_i) begin
            pass_cnt_d = '0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pass_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            pass_cnt_q <= pass_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign pkt_pass_cnt_o = pass_cnt_q;
    assign pkt_drop_cnt_o = drop_cnt_q;
`endif

endmodule
